// File: rtl/ap_s.sv
// ap_s: three bit-serial associative-processing CAMs (A, B, C = A op B) with access and compute modes
module ap_cam #(
  parameter int W  = 8,
  parameter int N  = 512,
  parameter int AW = 10
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 we,
  input  logic                 bit_we,
  input  logic                 bank,
  input  logic [AW-1:0]        addr,
  input  logic [W-1:0]         din,
  input  logic [$clog2(W)-1:0] bit_idx,
  input  logic [N-1:0]         bit_din,
  output logic [W-1:0]         cell_doutb_ctrl [N]
);
  logic [W-1:0] mem [2][N];
  always_ff @(posedge clk)
    if (clr)
      for (int i = 0; i < N; i++) mem[bank][i] <= '0;
    else if (we && int'(addr) < N)
      mem[bank][addr[$clog2(N)-1:0]] <= din;
    else if (bit_we)
      for (int i = 0; i < N; i++) mem[bank][i][bit_idx] <= bit_din[i];
  assign cell_doutb_ctrl = mem[bank];
endmodule

module ap_s #(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512,
  localparam int AW = $clog2(CELL_QUANT + 1)
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst,
  input  logic                 ap_mode,
  input  logic [2:0]           cmd,
  input  logic [1:0]           sel_col,
  input  logic                 sel_internal_col,
  input  logic [AW-1:0]        addr_in,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 write_en,
  input  logic                 read_en,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 ap_state_irq
);
  localparam int IW = $clog2(WORD_SIZE);
  localparam int LW = $clog2(CELL_QUANT);
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t state;
  logic [2:0] op;
  logic bank_l, bank, acc_we, bit_we, a, b, c;
  logic [IW-1:0] idx;
  logic [CELL_QUANT-1:0] carry, nc, bit_din;
  logic [WORD_SIZE-1:0] rows_a [CELL_QUANT];
  logic [WORD_SIZE-1:0] rows_b [CELL_QUANT];
  logic [WORD_SIZE-1:0] rows_c [CELL_QUANT];
  logic [WORD_SIZE-1:0] rd_word;
  // a running or finished computation keeps viewing the bank it latched
  assign bank   = (!rst && state != IDLE && ap_mode) ? bank_l : sel_internal_col;
  assign acc_we = !rst && !ap_mode && write_en;
  assign bit_we = !rst && ap_mode && state == COMPUTE && op < 3'd5;
  ap_cam #(.W(WORD_SIZE), .N(CELL_QUANT), .AW(AW)) cam_a (
    .clk(CLK100MHZ), .clr(rst), .we(acc_we && sel_col == 2'd0), .bit_we(1'b0), .bank(bank),
    .addr(addr_in), .din(data_in), .bit_idx(idx), .bit_din('0), .cell_doutb_ctrl(rows_a));
  ap_cam #(.W(WORD_SIZE), .N(CELL_QUANT), .AW(AW)) cam_b (
    .clk(CLK100MHZ), .clr(rst), .we(acc_we && sel_col == 2'd1), .bit_we(1'b0), .bank(bank),
    .addr(addr_in), .din(data_in), .bit_idx(idx), .bit_din('0), .cell_doutb_ctrl(rows_b));
  ap_cam #(.W(WORD_SIZE), .N(CELL_QUANT), .AW(AW)) cam_c (
    .clk(CLK100MHZ), .clr(rst), .we(acc_we && sel_col == 2'd2), .bit_we(bit_we), .bank(bank),
    .addr(addr_in), .din(data_in), .bit_idx(idx), .bit_din(bit_din), .cell_doutb_ctrl(rows_c));
  always_comb begin
    rd_word = '0;
    if (int'(addr_in) < CELL_QUANT)
      rd_word = sel_col == 2'd0 ? rows_a[addr_in[LW-1:0]] :
                sel_col == 2'd1 ? rows_b[addr_in[LW-1:0]] :
                sel_col == 2'd2 ? rows_c[addr_in[LW-1:0]] : '0;
  end
  // one bit slice of every row per cycle; carry doubles as borrow for SUB
  always_comb begin
    a = 1'b0;
    b = 1'b0;
    c = 1'b0;
    bit_din = '0;
    nc = '0;
    for (int i = 0; i < CELL_QUANT; i++) begin
      a = rows_a[i][idx];
      b = rows_b[i][idx];
      c = carry[i];
      bit_din[i] = op == 3'd0 ? a | b : op == 3'd1 ? a & b : op == 3'd2 ? a ^ b : a ^ b ^ c;
      nc[i] = op == 3'd4 ? (~a & b) | (~(a ^ b) & c) : (a & b) | (c & (a ^ b));
    end
  end
  always_ff @(posedge CLK100MHZ)
    if (rst) begin
      state <= IDLE;
      op <= '0;
      bank_l <= 1'b0;
      idx <= '0;
      carry <= '0;
      data_out <= '0;
      ap_state_irq <= 1'b0;
    end else begin
      if (!ap_mode && read_en && !write_en) data_out <= rd_word;
      case (state)
        IDLE: if (ap_mode) begin
          op <= cmd;
          bank_l <= sel_internal_col;
          idx <= '0;
          carry <= '0;
          state <= COMPUTE;
        end
        COMPUTE: if (!ap_mode) state <= IDLE;
        else begin
          carry <= nc;
          idx <= idx + 1'b1;
          if (idx == IW'(WORD_SIZE - 1)) begin
            state <= DONE;
            ap_state_irq <= 1'b1;
          end
        end
        default: if (!ap_mode) begin
          state <= IDLE;
          ap_state_irq <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_ap_s.sv
// tb_ap_s: directed and random checks of ap_s against an array-based arithmetic model
module tb_ap_s;
  localparam int W = 8;
  localparam int N = 512;
  logic clk = 0, rst = 0, ap_mode = 0, sel_internal_col = 0, write_en = 0, read_en = 0, ap_state_irq;
  logic [2:0] cmd = 0;
  logic [1:0] sel_col = 0;
  logic [9:0] addr_in = 0;
  logic [W-1:0] data_in = 0, data_out;
  logic [W-1:0] m [3][2][N];
  int total = 0, bad = 0;
  ap_s dut (.CLK100MHZ(clk), .rst(rst), .ap_mode(ap_mode), .cmd(cmd), .sel_col(sel_col),
            .sel_internal_col(sel_internal_col), .addr_in(addr_in), .data_in(data_in),
            .write_en(write_en), .read_en(read_en), .data_out(data_out), .ap_state_irq(ap_state_irq));
  always #5 clk = ~clk;
  function automatic logic [W-1:0] model_op(int op, logic [W-1:0] x, logic [W-1:0] y, logic [W-1:0] old);
    int r;
    r = op == 0 ? x | y : op == 1 ? x & y : op == 2 ? x ^ y : op == 3 ? x + y : op == 4 ? x - y : old;
    return W'(r);
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(logic bk);
    rst = 1;
    sel_internal_col = bk;
    tick();
    rst = 0;
    for (int c = 0; c < 3; c++) for (int i = 0; i < N; i++) m[c][bk][i] = '0;
    chk("rst_dout", data_out, 0);
    chk("rst_irq", ap_state_irq, 0);
  endtask
  task automatic wr(int col, logic bk, int addr, logic [W-1:0] d);
    sel_col = 2'(col);
    sel_internal_col = bk;
    addr_in = 10'(addr);
    data_in = d;
    write_en = 1;
    tick();
    write_en = 0;
    if (col < 3 && addr < N) m[col][bk][addr] = d;
  endtask
  task automatic rd_chk(string tag, int col, logic bk, int addr);
    sel_col = 2'(col);
    sel_internal_col = bk;
    addr_in = 10'(addr);
    read_en = 1;
    tick();
    read_en = 0;
    chk(tag, data_out, (col < 3 && addr < N) ? m[col][bk][addr] : 0);
  endtask
  task automatic check_bank(string tag, logic bk);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_a"}, dut.cam_a.cell_doutb_ctrl[i], m[0][bk][i]);
      chk({tag, "_b"}, dut.cam_b.cell_doutb_ctrl[i], m[1][bk][i]);
      chk({tag, "_c"}, dut.cam_c.cell_doutb_ctrl[i], m[2][bk][i]);
    end
  endtask
  task automatic run(int op, logic bk, string tag);
    int n;
    cmd = 3'(op);
    sel_internal_col = bk;
    ap_mode = 1;
    n = 0;
    while (!ap_state_irq && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, W + 1);
    for (int i = 0; i < N; i++) m[2][bk][i] = model_op(op, m[0][bk][i], m[1][bk][i], m[2][bk][i]);
    check_bank(tag, bk);
    tick();
    chk({tag, "_hold"}, ap_state_irq, 1);
    ap_mode = 0;
    tick();
    chk({tag, "_drop"}, ap_state_irq, 0);
  endtask
  initial begin
    do_reset(0);
    do_reset(1);
    for (int c = 0; c < 3; c++) for (int b = 0; b < 2; b++) rd_chk("s1_read", c, 1'(b), 5);
    chk("s1_irq", ap_state_irq, 0);
    wr(0, 0, 0, 171);
    wr(1, 0, 0, 167);
    run(0, 0, "s2_or");
    chk("s2_c0", dut.cam_c.cell_doutb_ctrl[0], 175);
    run(1, 0, "s3_and");
    chk("s3_and_c0", m[2][0][0], 163);
    chk("s3_and_rd", dut.cam_c.cell_doutb_ctrl[0], 163);
    run(2, 0, "s3_xor");
    chk("s3_xor_rd", dut.cam_c.cell_doutb_ctrl[0], 12);
    run(3, 0, "s3_add");
    chk("s3_add_rd", dut.cam_c.cell_doutb_ctrl[0], 82);
    run(4, 0, "s3_sub");
    chk("s3_sub_rd", dut.cam_c.cell_doutb_ctrl[0], 4);
    wr(0, 0, 0, 0);
    wr(1, 0, 0, 1);
    run(4, 0, "s3_sub01");
    chk("s3_sub01_rd", dut.cam_c.cell_doutb_ctrl[0], 255);
    rd_chk("c_read", 2, 0, 0);
    for (int i = 0; i < N; i++) begin
      wr(0, 0, i, W'($urandom));
      wr(1, 0, i, W'($urandom));
    end
    run(0, 0, "s4_or");
    for (int op = 1; op < 8; op++) begin
      for (int k = 0; k < 16; k++) begin
        wr(0, 0, $urandom_range(N - 1), W'($urandom));
        wr(1, 0, $urandom_range(N - 1), W'($urandom));
      end
      run(op, 0, "rnd_op");
    end
    wr(0, 0, 600, 8'h55);
    wr(3, 0, 7, 8'h66);
    check_bank("ign_wr", 0);
    rd_chk("oor_read", 0, 0, 600);
    rd_chk("col3_read", 3, 0, 7);
    rd_chk("pre_both", 1, 0, 9);
    sel_col = 0;
    addr_in = 10;
    data_in = 8'hA5;
    write_en = 1;
    read_en = 1;
    tick();
    write_en = 0;
    read_en = 0;
    m[0][0][10] = 8'hA5;
    chk("both_hold", data_out, m[1][0][9]);
    tick();
    chk("idle_hold", data_out, m[1][0][9]);
    rd_chk("both_wrote", 0, 0, 10);
    wr(0, 1, 3, 9);
    do_reset(0);
    rd_chk("s5_bank1", 0, 1, 3);
    rd_chk("s5_bank0", 0, 0, 3);
    chk("s5_val", data_out, 0);
    for (int i = 0; i < 4; i++) begin
      wr(0, 1, i, W'($urandom));
      wr(1, 1, i, W'($urandom));
      wr(2, 1, i, W'($urandom));
    end
    cmd = 3;
    sel_internal_col = 1;
    ap_mode = 1;
    tick();
    sel_col = 0;
    addr_in = 1;
    data_in = 8'hEE;
    for (int k = 0; k < 3; k++) begin
      write_en = k[0];
      tick();
      chk("s6_irq_run", ap_state_irq, 0);
    end
    write_en = 0;
    ap_mode = 0;
    tick();
    chk("s6_irq_abort", ap_state_irq, 0);
    for (int i = 0; i < N; i++)
      m[2][1][i] = (model_op(3, m[0][1][i], m[1][1][i], 0) & 8'h07) | (m[2][1][i] & 8'hF8);
    check_bank("s6_partial", 1);
    run(1, 1, "s6_restart");
    cmd = 0;
    sel_internal_col = 1;
    ap_mode = 1;
    tick();
    tick();
    tick();
    rst = 1;
    tick();
    rst = 0;
    ap_mode = 0;
    for (int c = 0; c < 3; c++) for (int i = 0; i < N; i++) m[c][1][i] = '0;
    chk("midrst_irq", ap_state_irq, 0);
    chk("midrst_dout", data_out, 0);
    check_bank("midrst", 1);
    rd_chk("midrst_b0", 0, 0, 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ap_s.md
AP_S -- requirements
Module: ap_s

Interface
REQ-001 The parameter WORD_SIZE SHALL default to 8 and SHALL set the bits per stored word.
REQ-002 The parameter CELL_QUANT SHALL default to 512 and SHALL set the rows per CAM.
REQ-003 The address width AW SHALL equal the bit count of CELL_QUANT (floor(log2)+1), i.e. 10 for 512.
REQ-004 The port CLK100MHZ SHALL be an input, 1 bit wide, and SHALL be the single clock; all logic is posedge.
REQ-005 The port rst SHALL be an input, 1 bit wide, and SHALL be the reset, which is synchronous and active-high.
REQ-006 The port ap_mode SHALL be an input, 1 bit wide: 0 selects access mode, 1 requests and holds computation.
REQ-007 The port cmd SHALL be an input, 3 bits wide, and SHALL carry the operation code.
REQ-008 The port sel_col SHALL be an input, 2 bits wide: 0 selects CAM A, 1 CAM B, 2 CAM C, 3 is reserved.
REQ-009 The port sel_internal_col SHALL be an input, 1 bit wide, and SHALL select internal bank 0 or 1 of every CAM.
REQ-010 The port addr_in SHALL be an input, AW bits wide, and SHALL carry the row address.
REQ-011 The port data_in SHALL be an input, WORD_SIZE bits wide, and SHALL carry the write data.
REQ-012 The port write_en SHALL be an input, 1 bit wide, and SHALL be the write strobe.
REQ-013 The port read_en SHALL be an input, 1 bit wide, and SHALL be the read strobe.
REQ-014 The port data_out SHALL be an output, WORD_SIZE bits wide, and SHALL carry the registered read data.
REQ-015 The port ap_state_irq SHALL be an output, 1 bit wide, and SHALL flag completion of a computation.

Function
REQ-016 The design SHALL have three CAM instances named cam_a, cam_b and cam_c, each holding 2 banks x CELL_QUANT words of WORD_SIZE bits.
REQ-017 Each CAM SHALL expose an internal array cell_doutb_ctrl[CELL_QUANT], which combinationally shows every row of the currently selected bank, for hierarchical checking.
REQ-018 An access-mode write SHALL occur when ap_mode=0 and write_en=1: on the clock edge, data_in is stored to CAM[sel_col], bank sel_internal_col, row addr_in.
REQ-019 A write with sel_col=3 or with addr_in>=CELL_QUANT SHALL be ignored.
REQ-020 An access-mode read SHALL occur when ap_mode=0, read_en=1 and write_en=0: data_out takes the selected word on the next edge (1-cycle latency) and holds it until the next read.
REQ-021 A read of sel_col=3 or of an out-of-range address SHALL return 0.
REQ-022 When write_en and read_en are both asserted, the write SHALL take priority and data_out SHALL hold its value.
REQ-023 The FSM SHALL have the states IDLE, COMPUTE and DONE.
REQ-024 In IDLE with ap_mode=1, the FSM SHALL latch cmd and sel_internal_col, clear the bit index and the per-row carry, and move to COMPUTE.
REQ-025 COMPUTE SHALL process one bit per cycle, LSB first, all rows in parallel, and SHALL last exactly WORD_SIZE cycles.
REQ-026 In COMPUTE, bit k of C SHALL be written from bit k of A and bit k of B, in the latched bank.
REQ-027 The cmd encoding SHALL be: 0 OR, 1 AND, 2 XOR, 3 ADD (A+B mod 2^WORD_SIZE, per-row carry).
REQ-028 cmd=4 SHALL be SUB (A-B mod 2^WORD_SIZE, per-row borrow).
REQ-029 cmd=5..7 SHALL leave C unchanged but SHALL use the same timing.
REQ-030 After the last bit, the FSM SHALL enter DONE and ap_state_irq SHALL rise on that edge; all C rows are final by then.
REQ-031 ap_state_irq SHALL stay high while ap_mode=1; when ap_mode=0 in DONE, the FSM SHALL return to IDLE and ap_state_irq SHALL drop on the next edge.
REQ-032 If ap_mode drops during COMPUTE, the operation SHALL abort to IDLE, the bits already written SHALL remain in C, and irq SHALL NOT assert.
REQ-033 While ap_mode=1, write_en and read_en SHALL be ignored.
REQ-034 A and B SHALL never be modified by computation.

Reset
REQ-035 When rst=1, the design SHALL clear every row of bank sel_internal_col in A, B and C to 0; the other bank SHALL be retained.
REQ-036 When rst=1, the FSM SHALL go to IDLE, and data_out and ap_state_irq SHALL go to 0.
REQ-037 rst SHALL take priority over write, read and compute, including a reset asserted mid-COMPUTE.
REQ-038 Both banks SHALL be cleared by two resets, one with sel_internal_col=0 and one with sel_internal_col=1.

Verification
REQ-039 Scenario 1: reset bank 0 then bank 1, then read A/B/C row 5 of each bank -> data_out=0 each time, irq=0.
REQ-040 Scenario 2: write A[0]=171 and B[0]=167 (bank 0), then ap_mode=1, cmd=0 -> irq rises after WORD_SIZE compute cycles and cam_c.cell_doutb_ctrl[0]=175.
REQ-041 Scenario 3: repeat scenario 2 with cmd=1 / 2 / 3 / 4 -> C[0]=163 / 12 / 82 / 4; repeat with A=0, B=1, cmd=4 -> C=255.
REQ-042 Scenario 4: fill all 512 rows of A and B with random data, then cmd=0 -> every C[i]=A[i]|B[i] at irq, checked via cell_doutb_ctrl, and A/B are unchanged.
REQ-043 Scenario 5: write bank 1 A[3]=9, then reset with sel_internal_col=0 -> bank-1 read of A[3]=9, bank-0 read of A[3]=0.
REQ-044 Scenario 6: drop ap_mode after 3 COMPUTE cycles -> irq stays 0, the FSM is IDLE, and a new ap_mode=1 restarts from bit 0; write_en pulses during COMPUTE do not alter A.
